// File: rtl/hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_controller_pkg
// Shared definitions for the pipeline hazard controller:
//   - FWD_SEL_LEN / fwd_sel_t : width and type of the EX operand-select code
//   - FWD_RF / FWD_MEM / FWD_WB : operand-select codes (regfile, MEM, WB)
//   - hc_state_e : memory-wait sequencer states (HC_RUN, HC_MEM_WAIT)
// -----------------------------------------------------------------------------
package hazard_controller_pkg;

  localparam int FWD_SEL_LEN = 2;

  typedef logic [FWD_SEL_LEN-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef enum logic {
    HC_RUN      = 1'b0,
    HC_MEM_WAIT = 1'b1
  } hc_state_e;

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// -----------------------------------------------------------------------------
// hazard_controller_fwd_select
// Per-operand comparator: checks one ID source register against the EX, MEM and
// WB destinations and returns the match flags plus the forwarding code (MEM
// has priority over WB because it holds the younger result).
// Ports:
//   src_i, use_i            source register index and "instruction reads it"
//   ex/mem/wb_rd_i, _we_i   stage destination index and register-write flag
//   ex/mem/wb_match_o       source matches that stage's pending write
//   fwd_o                   FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module hazard_controller_fwd_select
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_we_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_we_i,
  output logic                  ex_match_o,
  output logic                  mem_match_o,
  output logic                  wb_match_o,
  output fwd_sel_t              fwd_o
);

  // x0 is hard-wired to zero, so a write to it is never a real dependency.
  logic src_live;
  assign src_live = use_i && (src_i != '0);

  assign ex_match_o  = src_live && ex_we_i  && (src_i == ex_rd_i);
  assign mem_match_o = src_live && mem_we_i && (src_i == mem_rd_i);
  assign wb_match_o  = src_live && wb_we_i  && (src_i == wb_rd_i);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd_o = FWD_RF;
    if (mem_match_o)     fwd_o = FWD_MEM;
    else if (wb_match_o) fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Drives the stage-register enables/clears of a 5-stage pipeline: RAW hazard
// stalls at ID, EX operand forwarding selects, wrong-path squash on redirect,
// and a whole-pipe freeze while data memory is busy.
// Configuration macro: FORWARDING_EN
//   defined   : only load-use stalls; fwd_a/fwd_b select MEM (priority) or WB.
//   undefined : stall on any used source matching EX or MEM; fwd_a/fwd_b = 00.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   id_rs1/2, id_use_rs1/2            ID sources and their use flags
//   ex_rd, ex_reg_write, ex_is_load   EX destination info
//   mem_rd, mem_reg_write             MEM destination info
//   wb_rd, wb_reg_write               WB destination info
//   ex_redirect                       taken branch / jump resolved in EX
//   dmem_req, dmem_ready              data-memory handshake from MEM
//   stall_if, stall_id                hold PC / IF-ID
//   bubble_ex, flush_id               bubble into ID-EX / clear IF-ID
//   freeze                            hold every stage register
//   fwd_a, fwd_b                      EX operand select (00 RF, 01 MEM, 10 WB)
//   dmem_timeout                      sticky memory-timeout error
//   stall_cycles                      saturating count of stall/freeze cycles
// -----------------------------------------------------------------------------
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  ex_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  freeze,
  output fwd_sel_t              fwd_a,
  output fwd_sel_t              fwd_b,
  output logic                  dmem_timeout,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Source comparators
  // ---------------------------------------------------------------------------
  logic     rs1_ex_match, rs1_mem_match, rs1_wb_match;
  logic     rs2_ex_match, rs2_mem_match, rs2_wb_match;
  fwd_sel_t rs1_fwd, rs2_fwd;

  hazard_controller_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_i       (id_rs1),
    .use_i       (id_use_rs1),
    .ex_rd_i     (ex_rd),
    .ex_we_i     (ex_reg_write),
    .mem_rd_i    (mem_rd),
    .mem_we_i    (mem_reg_write),
    .wb_rd_i     (wb_rd),
    .wb_we_i     (wb_reg_write),
    .ex_match_o  (rs1_ex_match),
    .mem_match_o (rs1_mem_match),
    .wb_match_o  (rs1_wb_match),
    .fwd_o       (rs1_fwd)
  );

  hazard_controller_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_i       (id_rs2),
    .use_i       (id_use_rs2),
    .ex_rd_i     (ex_rd),
    .ex_we_i     (ex_reg_write),
    .mem_rd_i    (mem_rd),
    .mem_we_i    (mem_reg_write),
    .wb_rd_i     (wb_rd),
    .wb_we_i     (wb_reg_write),
    .ex_match_o  (rs2_ex_match),
    .mem_match_o (rs2_mem_match),
    .wb_match_o  (rs2_wb_match),
    .fwd_o       (rs2_fwd)
  );

  // ---------------------------------------------------------------------------
  // Data hazard policy
  // ---------------------------------------------------------------------------
  logic data_stall;

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: its data appears in MEM.
  assign data_stall = ex_is_load && (rs1_ex_match || rs2_ex_match);
  assign fwd_a      = rs1_fwd;
  assign fwd_b      = rs2_fwd;
`else
  // WB needs no stall: the register file writes in the first half-cycle.
  assign data_stall = rs1_ex_match || rs2_ex_match || rs1_mem_match || rs2_mem_match;
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
`endif

  // Some comparator outputs are only consumed in one build configuration.
  logic unused_sink;
  assign unused_sink = ^{ex_is_load, rs1_mem_match, rs2_mem_match,
                         rs1_wb_match, rs2_wb_match, rs1_fwd, rs2_fwd};

  // ---------------------------------------------------------------------------
  // Memory-wait sequencer
  // ---------------------------------------------------------------------------
  hc_state_e         state_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q;

  always_comb begin
    freeze = 1'b0;
    case (state_q)
      HC_MEM_WAIT: freeze = !dmem_ready;
      default:     freeze = dmem_req && !dmem_ready;
    endcase
  end

  // wait_cnt counts consecutive frozen cycles (0 while in HC_RUN), so the
  // entry cycle in HC_RUN is the first wait; it saturates at MEM_TIMEOUT.
  always_comb begin
    wait_cnt_d = '0;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                         : wait_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HC_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        HC_RUN:      if (dmem_req && !dmem_ready) state_q <= HC_MEM_WAIT;
        HC_MEM_WAIT: if (dmem_ready)              state_q <= HC_RUN;
        default:                                  state_q <= HC_RUN;
      endcase
      wait_cnt_q <= wait_cnt_d;
      // Sticky until reset; the sequencer keeps waiting regardless.
      if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) timeout_q <= 1'b1;
    end
  end

  assign dmem_timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // Stage controls. Freeze holds every stage register, so nothing may be
  // flushed or bubbled underneath it; a pending redirect simply waits in EX.
  // A redirect beats a load-use stall because the ID instruction is wrong-path.
  // ---------------------------------------------------------------------------
  logic redirect;
  assign redirect  = ex_redirect && !freeze;
  assign flush_id  = redirect;
  assign bubble_ex = !freeze && (redirect || data_stall);
  assign stall_if  = !freeze && !redirect && data_stall;
  assign stall_id  = stall_if;

  // ---------------------------------------------------------------------------
  // Stall-cycle performance counter (saturating)
  // ---------------------------------------------------------------------------
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall_if || freeze) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule
